// File: rtl/shift_multipass_ctrl.sv
// rtl/shift_multipass_ctrl.sv - multi-pass controller driving an external 8-bit barrel shifter
// Splits counts above STEP into several shifter passes, feeding S back as A each clock.
module shift_multipass_ctrl #(
  parameter int CNT_W = 5,
  parameter int STEP  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [7:0]       operand,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic [7:0]       alu_a,
  output logic [2:0]       alu_cnt,
  output logic [1:0]       alu_sel,
  input  logic [7:0]       alu_s,
  input  logic             alu_co
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_work;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_op;
  logic [7:0]       r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;

  logic [CNT_W-1:0] w_cnt_full;
  logic [CNT_W-1:0] w_rem_next;
  logic             w_last;
  logic             w_accept;

  assign w_cnt_full = (r_rem > STEP_W) ? STEP_W : r_rem;
  assign w_rem_next = r_rem - w_cnt_full;
  assign w_last     = (w_rem_next == '0);
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign alu_a   = r_work;
  assign alu_cnt = w_cnt_full[2:0];
  assign alu_sel = r_op;
  assign result  = r_result;
  assign carry   = r_carry;
  assign zero    = r_zero;
  assign neg     = r_neg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // A count of 0 still runs one Cnt=0 pass so the carry comes from the shifter itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work   <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_op   <= op;
      r_work <= operand;
      r_rem  <= count;
    end else if (r_state == S_RUN) begin
      r_work <= alu_s;
      r_rem  <= w_rem_next;
      if (w_last) begin
        r_result <= alu_s;
        r_carry  <= alu_co;
        r_zero   <= (alu_s == 8'h00);
        r_neg    <= alu_s[7];
      end
    end
  end

endmodule
